freq_meter: RTL and testbench
=============================

# freq_meter

Gated frequency counter: measures an asynchronous square-wave input by counting its rising edges over a fixed window of `clk` cycles. It is the measurement counterpart to the team's clock-divider blocks and is used to check divided outputs and external signals on-board. The result is latched once per window and flagged with a one-cycle valid pulse. Period measurement is an optional build-time feature.

## Interface

Parameters:
- `GATE_CYCLES`, 125000000: window length in `clk` cycles (1 s at 125 MHz); must be ≥ 2. The gate counter is `$clog2(GATE_CYCLES)` bits wide.
- `CNT_W`, 32: width of the edge count and period results.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `sig_in`, input, 1: signal under measurement, asynchronous to `clk`.
- `enable`, input, 1: measurement runs while high.
- `freq`, output, `CNT_W`: rising-edge count of the last completed window.
- `valid`, output, 1: one-cycle pulse when `freq` updates.
- `overflow`, output, 1: the last completed window's count saturated.
- `period`, output, `CNT_W`: only with `FREQ_METER_PERIOD_EN`.
- `period_valid`, output, 1: only with `FREQ_METER_PERIOD_EN`.

## Operation

- **Synchronizer:** `s1<=sig_in`, `s2<=s1`, `s3<=s2`. It runs whenever the block is out of reset, regardless of `enable`.
- **Edge detect:** `edge = s2 & ~s3`. A rising edge on `sig_in` reaches `edge` 2–3 cycles later.
- **IDLE state:**
  - Gate counter and edge counter are held at 0.
  - When `enable` is sampled high, move to MEASURE. The first window cycle is the next cycle.
- **MEASURE state:**
  - The gate counter runs 0 → `GATE_CYCLES-1`.
  - On each `edge`, the edge counter increments. It saturates at `2^CNT_W-1` and sets an internal sat flag.
- **End of window** (gate counter = `GATE_CYCLES-1` while `enable` is high):
  - `freq <= edge_cnt + edge`, saturated.
  - `overflow <=` sat flag, or the final add saturated.
  - `valid <= 1`.
  - Gate counter, edge counter and sat flag clear.
  - The next window starts immediately, with no dead cycle.
- **`enable` low during MEASURE:**
  - Abort and return to IDLE.
  - The partial count is discarded and no `valid` pulse is produced.
  - `freq` and `overflow` keep their previous values.
- **Reset:** `freq=0`, `valid=0`, `overflow=0`, `period=0`, `period_valid=0`. Counters, synchronizer and state return to 0/IDLE. Reset may be asserted mid-window; the window is lost.

## Timing

- **`valid` pulse:** asserted in the cycle after the window's last cycle. It is high for exactly 1 cycle, and `freq` and `overflow` become valid in that same cycle.
- **Valid cadence:** with `enable` held high, successive `valid` pulses are exactly `GATE_CYCLES` cycles apart. The first pulse comes `GATE_CYCLES+1` cycles after `enable` is first sampled high.
- **Window boundaries:**
  - An `edge` on the window's last cycle counts in that window.
  - An `edge` on the first cycle of the next window counts in the next window.
  - No edge is lost or double-counted across back-to-back windows.
- **Input rate limit:** `sig_in` must hold each level for at least 2 `clk` cycles, so the maximum measurable frequency is `clk/4`. Behaviour for faster inputs is undefined (undercount).
- **Between updates:** outputs hold stable between `valid` pulses.

## Configuration

- **`FREQ_METER_PERIOD_EN` defined:** adds period measurement, active while `enable` is high.
  - A period counter counts `clk` cycles since the last `edge`, saturating at `2^CNT_W-1`.
  - The first `edge` after entering MEASURE only arms the counter.
  - Each later `edge` sets `period <=` cycles since the previous edge (edge-to-edge distance) and pulses `period_valid` for 1 cycle, in the cycle after that `edge`.
  - `period_valid` may fire in the same cycle as `valid`.
  - Dropping `enable` disarms the counter; `period` holds its value.
- **Not defined:** the `period` and `period_valid` ports and their logic are absent. The block is otherwise identical.

## Test plan

All scenarios use `GATE_CYCLES=100` and `CNT_W=32` unless stated otherwise.

- **Steady input:** `sig_in` toggles every 5 cycles (period 10), `enable` high → `valid` every 100 cycles. `freq=10` and `overflow=0` from the second window on.
- **No input:** `sig_in` held 0, then held 1 → `freq=0` every window, `valid` still pulses every 100 cycles.
- **Saturation:** `CNT_W=4`, `sig_in` period 4 (25 edges per window) → `freq=15`, `overflow=1`. Then switch to period 10 → the next full window gives `freq=10`, `overflow=0`.
- **Abort and restart:** `enable` dropped at window cycle 50 → no `valid`, `freq` keeps its prior value. `enable` raised again → `valid` 101 cycles after it is sampled high.
- **Mid-window reset:** `reset` asserted at window cycle 60 → all outputs 0 immediately. After release with `enable` high → first `valid` `GATE_CYCLES+1` cycles later.
- **Period build (`FREQ_METER_PERIOD_EN`):** `sig_in` period 7 → no `period_valid` on the first edge. Every later edge gives `period=7` with a 1-cycle `period_valid`. `sig_in` stopped → no further `period_valid`.

Source files
------------

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter over a GATE_CYCLES window.
// Define FREQ_METER_PERIOD_EN to add edge-to-edge period measurement.
module freq_meter #(
  parameter int GATE_CYCLES = 125000000,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
`endif
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t            state_q, state_d;
  logic              s1_q, s2_q, s3_q;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic              edge_det;
  logic              cnt_full;

  always_comb begin
    edge_det   = s2_q & ~s3_q;
    cnt_full   = (edge_cnt_q == CNT_MAX);
    state_d    = state_q;
    gate_d     = gate_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        gate_d     = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (enable) state_d = MEASURE;
      end
      default: begin
        if (!enable) begin
          // Abort: partial window is dropped, published results untouched
          state_d    = IDLE;
          gate_d     = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else if (gate_q == GATE_LAST) begin
          freq_d     = cnt_full ? CNT_MAX : edge_cnt_q + CNT_W'(edge_det);
          overflow_d = sat_q | (cnt_full & edge_det);
          valid_d    = 1'b1;
          gate_d     = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          gate_d = gate_q + GATE_W'(1);
          if (edge_det) begin
            if (cnt_full) sat_d = 1'b1;
            else          edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_q     <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      gate_q     <= gate_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign freq     = freq_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;

  // per_cnt holds the distance from the last edge, so it loads 1 on an edge
  always_comb begin
    per_cnt_d      = per_cnt_q;
    armed_d        = armed_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    if (!(state_q == MEASURE && enable)) begin
      armed_d = 1'b0;
    end else if (edge_det) begin
      if (armed_q) begin
        period_d       = per_cnt_q;
        period_valid_d = 1'b1;
      end
      armed_d   = 1'b1;
      per_cnt_d = CNT_W'(1);
    end else if (per_cnt_q != CNT_MAX) begin
      per_cnt_d = per_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt_q      <= '0;
      armed_q        <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      per_cnt_q      <= per_cnt_d;
      armed_q        <= armed_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter
module tb_freq_meter;

  localparam int G = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic        gen_a = 1'b0, gen_b = 1'b0;
  logic        man_a = 1'b0, use_gen_a = 1'b0;
  logic        sig_a, sig_b;
  logic [31:0] freq_a;
  logic        valid_a, ovf_a;
  logic [3:0]  freq_b;
  logic        valid_b, ovf_b;
`ifdef FREQ_METER_PERIOD_EN
  logic [31:0] period_a;
  logic        pv_a;
  logic [3:0]  period_b;
  logic        pv_b;
`endif

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int hi_a = 5, lo_a = 5, ph_a = 0;
  int hi_b = 2, lo_b = 2, ph_b = 0;
  int at, at_prev, c0, cnt;

  assign sig_a = use_gen_a ? gen_a : man_a;
  assign sig_b = gen_b;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .sig_in(sig_a), .enable(en_a),
    .freq(freq_a), .valid(valid_a), .overflow(ovf_a)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period_a), .period_valid(pv_a)
`endif
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .sig_in(sig_b), .enable(en_b),
    .freq(freq_b), .valid(valid_b), .overflow(ovf_b)
`ifdef FREQ_METER_PERIOD_EN
    , .period(period_b), .period_valid(pv_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    ph_a++;
    if (ph_a >= (gen_a ? hi_a : lo_a)) begin gen_a = ~gen_a; ph_a = 0; end
  end

  initial forever begin
    @(negedge clk);
    ph_b++;
    if (ph_b >= (gen_b ? hi_b : lo_b)) begin gen_b = ~gen_b; ph_b = 0; end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input bit sel, input int bound, output int found);
    found = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sel ? valid_b : valid_a) begin
        found = cyc;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_freq", freq_a, 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_freq_b", {28'd0, freq_b}, 32'd0);
`ifdef FREQ_METER_PERIOD_EN
    check("rst_period", period_a, 32'd0);
    check("rst_pv", 32'(pv_a), 32'd0);
`endif
    reset = 1'b0;

    // steady period-10 input
    use_gen_a = 1'b1;
    repeat (10) @(negedge clk);
    en_a = 1'b1;
    c0 = cyc;
    wait_valid(0, 250, at);
    check("first_latency", 32'(at - c0), 32'(G + 1));
    @(negedge clk);
    check("valid_width", 32'(valid_a), 32'd0);
    at_prev = at;
    wait_valid(0, 250, at);
    check("cadence_1", 32'(at - at_prev), 32'(G));
    check("steady_freq_1", freq_a, 32'd10);
    check("steady_ovf_1", 32'(ovf_a), 32'd0);
    at_prev = at;
    wait_valid(0, 250, at);
    check("cadence_2", 32'(at - at_prev), 32'(G));
    check("steady_freq_2", freq_a, 32'd10);

    // no input: held low, then held high
    use_gen_a = 1'b0;
    man_a = 1'b0;
    wait_valid(0, 250, at);
    at_prev = at;
    wait_valid(0, 250, at);
    check("low_cadence", 32'(at - at_prev), 32'(G));
    check("low_freq", freq_a, 32'd0);
    man_a = 1'b1;
    wait_valid(0, 250, at);
    at_prev = at;
    wait_valid(0, 250, at);
    check("high_cadence", 32'(at - at_prev), 32'(G));
    check("high_freq", freq_a, 32'd0);

    // back to period 10, then abort at window cycle 50
    use_gen_a = 1'b1;
    wait_valid(0, 250, at);
    wait_valid(0, 250, at);
    check("pre_abort_freq", freq_a, 32'd10);
    repeat (50) @(negedge clk);
    en_a = 1'b0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (valid_a) cnt++;
    end
    check("abort_no_valid", 32'(cnt), 32'd0);
    check("abort_freq_hold", freq_a, 32'd10);
    en_a = 1'b1;
    c0 = cyc;
    wait_valid(0, 250, at);
    check("restart_latency", 32'(at - c0), 32'(G + 1));
    check("restart_freq", freq_a, 32'd10);

    // reset at window cycle 60
    repeat (60) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_freq", freq_a, 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_ovf", 32'(ovf_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    wait_valid(0, 250, at);
    check("postrst_latency", 32'(at - c0), 32'(G + 1));

    // saturation on the 4-bit instance: 25 edges per window
    en_b = 1'b1;
    wait_valid(1, 250, at);
    wait_valid(1, 250, at);
    check("sat_freq", {28'd0, freq_b}, 32'd15);
    check("sat_ovf", 32'(ovf_b), 32'd1);
    hi_b = 5;
    lo_b = 5;
    wait_valid(1, 250, at);
    wait_valid(1, 250, at);
    check("unsat_freq", {28'd0, freq_b}, 32'd10);
    check("unsat_ovf", 32'(ovf_b), 32'd0);

`ifdef FREQ_METER_PERIOD_EN
    // period 7 driven by hand; rises at t=0,7,..,77 give pulses at t=10..80
    en_a = 1'b0;
    use_gen_a = 1'b0;
    man_a = 1'b0;
    repeat (5) @(negedge clk);
    en_a = 1'b1;
    repeat (5) @(negedge clk);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      check($sformatf("pv_t%0d", t), 32'(pv_a),
            32'((t >= 10) && (t <= 80) && ((t - 10) % 7 == 0)));
      if (pv_a) check($sformatf("period_t%0d", t), period_a, 32'd7);
      man_a = (t < 84) && ((t % 7) < 3);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
